asansor_denetleyici: RTL and testbench

ASANSOR_DENETLEYICI -- requirements
Module: asansor_denetleyici

---
 rtl/asansor_pkg.sv | 14 +
 rtl/asansor_zamanlayici.sv | 18 +
 rtl/asansor_denetleyici.sv | 79 +++++++
 tb/tb_asansor_denetleyici.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/asansor_pkg.sv
// asansor_pkg: shared types, direction codes and request-mask helper for the elevator controller
package asansor_pkg;
  typedef enum logic [1:0] {BEKLE = 2'd0, YUKARI = 2'd1, ASAGI = 2'd2, KAPI = 2'd3} durum_t;
  localparam logic [1:0] YON_BOS    = 2'b00;
  localparam logic [1:0] YON_YUKARI = 2'b01;
  localparam logic [1:0] YON_ASAGI  = 2'b10;
  localparam int KAT_MAKS = 16;
  // bit i set when floor i lies strictly above (yukari=1) or strictly below (yukari=0) kat
  function automatic logic [KAT_MAKS-1:0] yon_maske(input logic [3:0] kat, input logic yukari);
    logic [KAT_MAKS-1:0] m;
    for (int i = 0; i < KAT_MAKS; i++) m[i] = yukari ? (i > int'(kat)) : (i < int'(kat));
    return m;
  endfunction
endpackage

// File: rtl/asansor_zamanlayici.sv
// asansor_zamanlayici: loadable down-counter that saturates at zero and flags it
module asansor_zamanlayici #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_yukle,
  input  logic [W-1:0] i_deger,
  input  logic         i_azalt,
  output logic         o_sifir
);
  logic [W-1:0] r_sayac;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sayac <= '0;
    else if (i_yukle) r_sayac <= i_deger;
    else if (i_azalt && r_sayac != '0) r_sayac <= r_sayac - 1'b1;
  assign o_sifir = r_sayac == '0;
endmodule

// File: rtl/asansor_denetleyici.sv
// asansor_denetleyici: SCAN-order elevator controller with move and door timing
module asansor_denetleyici
  import asansor_pkg::*;
#(
  parameter int KAT_SAYISI   = 4,
  parameter int KAT_GENISLIK = $clog2(KAT_SAYISI),
  parameter int HAREKET_SURE = 4,
  parameter int KAPI_SURE    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [KAT_SAYISI-1:0]   buton,
  output logic [KAT_GENISLIK-1:0] bulundugu_kat,
  output logic [1:0]              yon,
  output logic                    kapi_acik,
  output logic [KAT_SAYISI-1:0]   istek
);
  localparam int SURE_MAKS = HAREKET_SURE > KAPI_SURE ? HAREKET_SURE : KAPI_SURE;
  localparam int SW = $clog2(SURE_MAKS + 1);
  localparam logic [SW-1:0] HAREKET_YUK = SW'(HAREKET_SURE - 1);
  localparam logic [SW-1:0] KAPI_YUK = SW'(KAPI_SURE - 1);
  localparam logic [KAT_SAYISI-1:0] BIR = {{(KAT_SAYISI-1){1'b0}}, 1'b1};
  durum_t r_durum, w_durum_sonraki, w_secim;
  logic [KAT_GENISLIK-1:0] r_kat, w_yeni_kat, w_kat_sonraki;
  logic [KAT_SAYISI-1:0] r_istek, w_istek_sonraki, w_kat_biti, w_ust_maske, w_alt_maske;
  logic [1:0] r_yon;
  logic r_kapi, r_son_yukari, w_var_ust, w_var_alt, w_hareket, w_adim, w_sonraki_hareket;
  logic w_hareket_sifir, w_kapi_sifir, w_kapi_uzat, w_kapi_bitti;
  assign w_ust_maske = KAT_SAYISI'(yon_maske(4'(r_kat), 1'b1));
  assign w_alt_maske = KAT_SAYISI'(yon_maske(4'(r_kat), 1'b0));
  assign w_var_ust = |(r_istek & w_ust_maske);
  assign w_var_alt = |(r_istek & w_alt_maske);
  // keep sweeping in the last direction while it has work, otherwise reverse
  assign w_secim = r_son_yukari ? (w_var_ust ? YUKARI : w_var_alt ? ASAGI : BEKLE)
                                : (w_var_alt ? ASAGI : w_var_ust ? YUKARI : BEKLE);
  assign w_hareket = r_durum == YUKARI || r_durum == ASAGI;
  assign w_adim = w_hareket && w_hareket_sifir;
  assign w_yeni_kat = r_durum == YUKARI ? r_kat + 1'b1 : r_kat - 1'b1;
  assign w_kat_sonraki = w_adim ? w_yeni_kat : r_kat;
  assign w_kapi_uzat = r_durum == KAPI && buton[r_kat];
  assign w_kapi_bitti = r_durum == KAPI && w_kapi_sifir && !buton[r_kat];
  assign w_durum_sonraki = r_durum == BEKLE ? (r_istek[r_kat] ? KAPI : w_secim) :
                           (w_adim && r_istek[w_yeni_kat]) ? KAPI :
                           w_kapi_bitti ? w_secim : r_durum;
  assign w_sonraki_hareket = w_durum_sonraki == YUKARI || w_durum_sonraki == ASAGI;
  // the floor being served never latches a request while its door is open
  assign w_kat_biti = (r_durum == KAPI || w_durum_sonraki == KAPI) ? BIR << w_kat_sonraki : '0;
  assign w_istek_sonraki = (r_istek | buton) & ~w_kat_biti;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_durum <= BEKLE;
      r_kat <= '0;
      r_yon <= YON_BOS;
      r_kapi <= 1'b0;
      r_istek <= '0;
      r_son_yukari <= 1'b1;
    end else begin
      r_durum <= w_durum_sonraki;
      r_kat <= w_kat_sonraki;
      r_yon <= w_durum_sonraki == YUKARI ? YON_YUKARI : w_durum_sonraki == ASAGI ? YON_ASAGI : YON_BOS;
      r_kapi <= w_durum_sonraki == KAPI;
      r_istek <= w_istek_sonraki;
      if (w_sonraki_hareket) r_son_yukari <= w_durum_sonraki == YUKARI;
    end
  asansor_zamanlayici #(.W(SW)) u_hareket (
    .clk(clk), .rst_n(rst_n),
    .i_yukle(w_sonraki_hareket && (w_durum_sonraki != r_durum || w_adim)),
    .i_deger(HAREKET_YUK), .i_azalt(w_hareket), .o_sifir(w_hareket_sifir)
  );
  asansor_zamanlayici #(.W(SW)) u_kapi (
    .clk(clk), .rst_n(rst_n),
    .i_yukle((w_durum_sonraki == KAPI && r_durum != KAPI) || w_kapi_uzat),
    .i_deger(KAPI_YUK), .i_azalt(r_durum == KAPI), .o_sifir(w_kapi_sifir)
  );
  assign bulundugu_kat = r_kat;
  assign yon = r_yon;
  assign kapi_acik = r_kapi;
  assign istek = r_istek;
endmodule

// File: tb/tb_asansor_denetleyici.sv
// tb_asansor_denetleyici: directed self-checking bench for the elevator controller
module tb_asansor_denetleyici;
  logic clk, rst_n;
  logic [3:0] buton;
  logic [1:0] bulundugu_kat, yon;
  logic kapi_acik;
  logic [3:0] istek;
  int n_test = 0, n_fail = 0, n;
  asansor_denetleyici #(.KAT_SAYISI(4), .HAREKET_SURE(4), .KAPI_SURE(8)) dut (
    .clk(clk), .rst_n(rst_n), .buton(buton), .bulundugu_kat(bulundugu_kat),
    .yon(yon), .kapi_acik(kapi_acik), .istek(istek)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic kapi_say(output int c);
    c = 0;
    while (kapi_acik === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
  endtask
  task automatic bas(input logic [3:0] b);
    buton = b;
    tick(1);
    buton = 4'b0000;
  endtask
  initial begin
    buton = 4'b0000;
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("reset_kat", bulundugu_kat, 0);
    chk("reset_yon", yon, 2'b00);
    chk("reset_kapi", kapi_acik, 0);
    chk("reset_istek", istek, 4'b0000);
    tick(2);
    rst_n = 1;
    // same-floor call at floor 0
    bas(4'b0001);
    chk("ayni_kat_istek", istek, 4'b0001);
    chk("ayni_kat_kapi_gec", kapi_acik, 0);
    tick(1);
    chk("ayni_kat_kapi", kapi_acik, 1);
    chk("ayni_kat_istek_sil", istek, 4'b0000);
    kapi_say(n);
    chk("ayni_kat_kapi_sure", n, 8);
    chk("ayni_kat_kat", bulundugu_kat, 0);
    // trip 0 -> 3
    bas(4'b1000);
    chk("yukari_istek", istek, 4'b1000);
    chk("yukari_yon_gec", yon, 2'b00);
    tick(1);
    chk("yukari_yon", yon, 2'b01);
    tick(3);
    chk("yukari_kat0", bulundugu_kat, 0);
    tick(1);
    chk("yukari_kat1", bulundugu_kat, 1);
    tick(4);
    chk("yukari_kat2", bulundugu_kat, 2);
    tick(3);
    chk("yukari_yon_son", yon, 2'b01);
    tick(1);
    chk("yukari_kat3", bulundugu_kat, 3);
    chk("yukari_kapi", kapi_acik, 1);
    chk("yukari_yon_kapi", yon, 2'b00);
    chk("yukari_istek_sil", istek, 4'b0000);
    kapi_say(n);
    chk("yukari_kapi_sure", n, 8);
    chk("yukari_bos", yon, 2'b00);
    // 3 -> 2, door extended at door cycle 5
    bas(4'b0100);
    tick(1);
    chk("asagi_yon", yon, 2'b10);
    tick(4);
    chk("uzat_kat", bulundugu_kat, 2);
    chk("uzat_kapi", kapi_acik, 1);
    tick(4);
    chk("uzat_kapi_c4", kapi_acik, 1);
    bas(4'b0100);
    chk("uzat_istek_yok", istek, 4'b0000);
    kapi_say(n);
    chk("uzat_kapi_kalan", n, 8);
    // idle at 2 heading down, calls at 0 and 3
    bas(4'b1001);
    chk("scan_istek", istek, 4'b1001);
    tick(1);
    chk("scan_yon_asagi", yon, 2'b10);
    tick(8);
    chk("scan_kat0", bulundugu_kat, 0);
    chk("scan_kapi0", kapi_acik, 1);
    chk("scan_istek_kalan", istek, 4'b1000);
    kapi_say(n);
    chk("scan_kapi0_sure", n, 8);
    chk("scan_yon_yukari", yon, 2'b01);
    tick(12);
    chk("scan_kat3", bulundugu_kat, 3);
    chk("scan_kapi3", kapi_acik, 1);
    kapi_say(n);
    chk("scan_kapi3_sure", n, 8);
    // back to floor 0
    bas(4'b0001);
    tick(1);
    chk("donus_yon", yon, 2'b10);
    tick(12);
    chk("donus_kat0", bulundugu_kat, 0);
    kapi_say(n);
    chk("donus_kapi_sure", n, 8);
    // intermediate stop and reversal for a departed floor
    bas(4'b1000);
    tick(1);
    chk("ara_yon", yon, 2'b01);
    tick(4);
    chk("ara_kat1", bulundugu_kat, 1);
    bas(4'b0101);
    chk("ara_istek", istek, 4'b1101);
    tick(3);
    chk("ara_kat2", bulundugu_kat, 2);
    chk("ara_kapi2", kapi_acik, 1);
    chk("ara_istek2", istek, 4'b1001);
    kapi_say(n);
    chk("ara_kapi2_sure", n, 8);
    chk("ara_yon_devam", yon, 2'b01);
    tick(4);
    chk("ara_kat3", bulundugu_kat, 3);
    chk("ara_istek3", istek, 4'b0001);
    kapi_say(n);
    chk("ara_kapi3_sure", n, 8);
    chk("ara_yon_ters", yon, 2'b10);
    tick(12);
    chk("ara_kat0", bulundugu_kat, 0);
    chk("ara_kapi0", kapi_acik, 1);
    chk("ara_istek0", istek, 4'b0000);
    kapi_say(n);
    chk("ara_kapi0_sure", n, 8);
    // reset between floors 1 and 2
    bas(4'b0100);
    tick(5);
    chk("rst_kat1", bulundugu_kat, 1);
    tick(2);
    #2 rst_n = 0;
    #1;
    chk("rst_kat", bulundugu_kat, 0);
    chk("rst_yon", yon, 2'b00);
    chk("rst_kapi", kapi_acik, 0);
    chk("rst_istek", istek, 4'b0000);
    tick(1);
    rst_n = 1;
    tick(5);
    chk("rst_sonra_kat", bulundugu_kat, 0);
    chk("rst_sonra_yon", yon, 2'b00);
    chk("rst_sonra_istek", istek, 4'b0000);
    bas(4'b0001);
    tick(1);
    chk("rst_sonra_kapi", kapi_acik, 1);
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end
endmodule
